uart_rx_word_packer: RTL and testbench

- UART receiver (8N1, LSB first) that sits directly downstream of the board uart_rx pin and upstream of the DDR3 write-FIFO input of the test top.
- Samples the serial line and packs received bytes pairwise into 16-bit words.
- Presents words on a valid/ready interface matching the 16-bit write-FIFO input width.
- Flags framing errors and overflow.

---
 rtl/uart_pkg.sv | 42 ++++
 rtl/uart_rx_byte.sv | 122 ++++++++++++
 rtl/uart_rx_word_packer.sv | 80 ++++++++
 tb/tb_uart_rx_word_packer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: baud divisors, baud_sel encoding, FSM states.
package uart_pkg;

    localparam int unsigned CLK_FREQ = 50_000_000;
    localparam int unsigned DIV_W    = 13;

    typedef logic [DIV_W-1:0] div_t;

    // Clocks per bit at 50 MHz
    localparam div_t BAUD_9600   = 13'd5208;
    localparam div_t BAUD_19200  = 13'd2604;
    localparam div_t BAUD_38400  = 13'd1302;
    localparam div_t BAUD_57600  = 13'd868;
    localparam div_t BAUD_115200 = 13'd434;

    localparam logic [2:0] SEL_9600   = 3'd0;
    localparam logic [2:0] SEL_19200  = 3'd1;
    localparam logic [2:0] SEL_38400  = 3'd2;
    localparam logic [2:0] SEL_57600  = 3'd3;
    localparam logic [2:0] SEL_115200 = 3'd4;

    localparam int unsigned WORD_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_e;

    // Unused encodings 5..7 fall back to the fastest rate
    function automatic div_t baud_div(input logic [2:0] sel);
        case (sel)
            SEL_9600:  return BAUD_9600;
            SEL_19200: return BAUD_19200;
            SEL_38400: return BAUD_38400;
            SEL_57600: return BAUD_57600;
            default:   return BAUD_115200;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: synchronizer, edge detect and bit-timing FSM.
module uart_rx_byte
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] baud_sel,
    input  logic       uart_rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err
);

    logic        sync1_q, sync2_q, prev_q;
    logic        rx_fall;

    uart_state_e state_q, state_d;
    div_t        div_q, div_d;
    div_t        baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  byte_data_q, byte_data_d;
    logic        byte_valid_q, byte_valid_d;
    logic        frame_err_q, frame_err_d;
    div_t        half_m1, full_m1;

    assign rx_fall = prev_q & ~sync2_q;
    assign half_m1 = (div_q >> 1) - div_t'(1);
    assign full_m1 = div_q - div_t'(1);

    // Two-flop synchronizer plus one delay flop for falling-edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= uart_rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Receiver state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            div_q        <= BAUD_115200;
            baud_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            byte_data_q  <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            baud_cnt_q   <= baud_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_data_q  <= byte_data_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Next-state: mid-bit start check, then full-bit data/stop sampling
    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        baud_cnt_d   = baud_cnt_q + div_t'(1);
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_data_d  = byte_data_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                baud_cnt_d = '0;
                if (rx_fall) begin
                    state_d = ST_START;
                    div_d   = baud_div(baud_sel);
                end
            end
            ST_START: begin
                if (baud_cnt_q == half_m1) begin
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = sync2_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_cnt_q == full_m1) begin
                    baud_cnt_d = '0;
                    shift_d    = {sync2_q, shift_q[7:1]};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (baud_cnt_q == full_m1) begin
                    baud_cnt_d = '0;
                    state_d    = ST_IDLE;
                    if (sync2_q) begin
                        byte_valid_d = 1'b1;
                        byte_data_d  = shift_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign byte_data  = byte_data_q;
    assign byte_valid = byte_valid_q;
    assign frame_err  = frame_err_q;

endmodule

// File: rtl/uart_rx_word_packer.sv
// UART receiver packing byte pairs into 16-bit words on a valid/ready port.
module uart_rx_word_packer
    import uart_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            baud_sel,
    input  logic                  uart_rx,
    output logic [WORD_WIDTH-1:0] word_data,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic [7:0]            byte_data,
    output logic                  byte_valid,
    output logic                  frame_err,
    output logic                  overflow
);

    logic [7:0]            hi_byte_q, hi_byte_d;
    logic                  hi_full_q, hi_full_d;
    logic [WORD_WIDTH-1:0] word_data_q, word_data_d;
    logic                  word_valid_q, word_valid_d;
    logic                  overflow_q, overflow_d;

    uart_rx_byte u_rx (
        .clk        (clk),
        .rst        (rst),
        .baud_sel   (baud_sel),
        .uart_rx    (uart_rx),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    // Packer and output word registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_byte_q    <= '0;
            hi_full_q    <= 1'b0;
            word_data_q  <= '0;
            word_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            hi_byte_q    <= hi_byte_d;
            hi_full_q    <= hi_full_d;
            word_data_q  <= word_data_d;
            word_valid_q <= word_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    // Pair bytes; a framing error drops a pending high byte to re-align words
    always_comb begin
        hi_byte_d    = hi_byte_q;
        hi_full_d    = hi_full_q;
        word_data_d  = word_data_q;
        word_valid_d = word_valid_q & ~word_ready;
        overflow_d   = 1'b0;
        if (frame_err) begin
            hi_full_d = 1'b0;
        end else if (byte_valid) begin
            if (!hi_full_q) begin
                hi_byte_d = byte_data;
                hi_full_d = 1'b1;
            end else begin
                hi_full_d = 1'b0;
                if (!word_valid_q || word_ready) begin
                    word_data_d  = {hi_byte_q, byte_data};
                    word_valid_d = 1'b1;
                end else begin
                    overflow_d = 1'b1;
                end
            end
        end
    end

    assign word_data  = word_data_q;
    assign word_valid = word_valid_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Directed self-checking bench for uart_rx_word_packer.
module tb_uart_rx_word_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  baud_sel = 3'd4;
    logic        uart_rx = 1'b1;
    logic [15:0] word_data;
    logic        word_valid;
    logic        word_ready = 1'b0;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        frame_err;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    int n_bv = 0, n_fe = 0, n_ov = 0, n_words = 0;
    int cyc = 0, t_bv = 0;
    logic [15:0] last_word = '0;

    int bv0, fe0, ov0, w0, t0, dt;

    uart_rx_word_packer dut (
        .clk        (clk),
        .rst        (rst),
        .baud_sel   (baud_sel),
        .uart_rx    (uart_rx),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    // 50 MHz clock
    always #10 clk = ~clk;

    // Cycle counter for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse and transfer monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (byte_valid) begin
                n_bv++;
                t_bv = cyc;
            end
            if (frame_err) n_fe++;
            if (overflow)  n_ov++;
            if (word_valid && word_ready) begin
                n_words++;
                last_word = word_data;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n clocks, leaving time just after the rising edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int div);
        uart_rx = 1'b0;
        step(div);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            step(div);
        end
        uart_rx = stop_bit;
        step(div);
        uart_rx = 1'b1;
        if (!stop_bit) step(div);
    endtask

    initial begin
        // Reset state
        step(3);
        @(negedge clk);
        chk("rst_word_valid", word_valid, 0);
        chk("rst_word_data", word_data, 0);
        chk("rst_byte_data", byte_data, 0);
        chk("rst_byte_valid", byte_valid, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_overflow", overflow, 0);
        step(1);
        rst = 1'b0;
        step(5);

        // 0x12,0x34 back-to-back, sel 5 aliases 115200, held until ready
        baud_sel = 3'd5;
        word_ready = 1'b0;
        bv0 = n_bv; fe0 = n_fe; ov0 = n_ov; w0 = n_words;
        send_byte(8'h12, 1'b1, 434);
        send_byte(8'h34, 1'b1, 434);
        step(20);
        @(negedge clk);
        chk("t1_bv_count", n_bv - bv0, 2);
        chk("t1_byte_data", byte_data, 8'h34);
        chk("t1_word_valid", word_valid, 1);
        chk("t1_word_data", word_data, 16'h1234);
        chk("t1_no_errs", (n_fe - fe0) + (n_ov - ov0), 0);
        step(10);
        @(negedge clk);
        chk("t1_hold_valid", word_valid, 1);
        chk("t1_hold_data", word_data, 16'h1234);
        word_ready = 1'b1;
        step(1);
        @(negedge clk);
        chk("t1_valid_drop", word_valid, 0);
        chk("t1_accepted", n_words - w0, 1);
        chk("t1_acc_word", last_word, 16'h1234);

        // 38400 baud, 0xA5,0x5A with latency of second byte
        baud_sel = 3'd2;
        step(50);
        w0 = n_words;
        t0 = cyc;
        send_byte(8'hA5, 1'b1, 1302);
        send_byte(8'h5A, 1'b1, 1302);
        step(20);
        @(negedge clk);
        chk("t2_word", last_word, 16'hA55A);
        chk("t2_words", n_words - w0, 1);
        dt = t_bv - t0 - 20 * 1302;
        if (dt < 0) dt = -dt;
        chk("t2_latency_ok", (dt <= 1302) ? 1 : 0, 1);

        // Framing error re-aligns pairing: 0x99, bad 0x11, 0x22, 0x33
        baud_sel = 3'd7;
        bv0 = n_bv; fe0 = n_fe; w0 = n_words;
        send_byte(8'h99, 1'b1, 434);
        send_byte(8'h11, 1'b0, 434);
        send_byte(8'h22, 1'b1, 434);
        send_byte(8'h33, 1'b1, 434);
        step(20);
        @(negedge clk);
        chk("t3_fe_count", n_fe - fe0, 1);
        chk("t3_bv_count", n_bv - bv0, 3);
        chk("t3_words", n_words - w0, 1);
        chk("t3_word", last_word, 16'h2233);

        // 0.2-bit glitch on idle line
        baud_sel = 3'd4;
        bv0 = n_bv; fe0 = n_fe; w0 = n_words;
        uart_rx = 1'b0;
        step(87);
        uart_rx = 1'b1;
        step(600);
        @(negedge clk);
        chk("t4_no_bv", n_bv - bv0, 0);
        chk("t4_no_fe", n_fe - fe0, 0);
        chk("t4_no_word", word_valid, 0);

        // Overflow: ready low across two words
        word_ready = 1'b0;
        ov0 = n_ov; w0 = n_words;
        send_byte(8'h01, 1'b1, 434);
        send_byte(8'h02, 1'b1, 434);
        send_byte(8'h03, 1'b1, 434);
        send_byte(8'h04, 1'b1, 434);
        step(20);
        @(negedge clk);
        chk("t5_valid", word_valid, 1);
        chk("t5_data_held", word_data, 16'h0102);
        chk("t5_ov_count", n_ov - ov0, 1);
        word_ready = 1'b1;
        step(1);
        @(negedge clk);
        chk("t5_valid_drop", word_valid, 0);
        step(500);
        @(negedge clk);
        chk("t5_no_more", word_valid, 0);
        chk("t5_words", n_words - w0, 1);
        chk("t5_acc_word", last_word, 16'h0102);

        // Reset mid-frame with a word pending and 0xAB in hi_byte
        word_ready = 1'b0;
        send_byte(8'h77, 1'b1, 434);
        send_byte(8'h88, 1'b1, 434);
        send_byte(8'hAB, 1'b1, 434);
        step(20);
        @(negedge clk);
        chk("t6_pending", word_data, 16'h7788);
        step(1);
        uart_rx = 1'b0;
        step(434);
        uart_rx = 1'b1;
        step(434 * 4 + 217);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", word_valid, 0);
        chk("t6_rst_data", word_data, 0);
        chk("t6_rst_byte", byte_data, 0);
        chk("t6_rst_pulses", {byte_valid, frame_err, overflow}, 0);
        step(5);
        rst = 1'b0;
        step(434 * 5);
        word_ready = 1'b1;
        ov0 = n_ov; w0 = n_words;
        send_byte(8'hC0, 1'b1, 434);
        send_byte(8'hDE, 1'b1, 434);
        step(20);
        @(negedge clk);
        chk("t6_words", n_words - w0, 1);
        chk("t6_word", last_word, 16'hC0DE);
        chk("t6_no_ov", n_ov - ov0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
